// File: rtl/sc_rand_spawn_scheduler_pkg.sv
// +--------------------------------------------------------------------------+
// | sc_spawn_pkg : shared state encoding and width helper for spawn logic     |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package sc_spawn_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] DRAW  = 2'd2;
   localparam logic [1:0] OFFER = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_COUNT = COUNT,
      ST_DRAW  = DRAW,
      ST_OFFER = OFFER
   } spawn_state_t;

   localparam logic [7:0] COUNT_SAT = 8'd255;

   // Bits needed to index n items, never less than 1.
   function automatic int sc_col_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sc_rand_spawn_scheduler_timer.sv
// +--------------------------------------------------------------------------+
// | sc_spawn_timer : loadable down-counter, expire_o flags a value of 1       |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_spawn_timer #(
   parameter int PERIOD_W = 26
) (
   input  logic                SC_RegSHIFTER_CLOCK_50,
   input  logic                SC_RegSHIFTER_RESET_InHigh,
   input  logic                load_i,
   input  logic [PERIOD_W-1:0] load_val_i,
   input  logic                dec_i,
   output logic                expire_o
);

   logic [PERIOD_W-1:0] value_q;
   logic [PERIOD_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load_i) begin
         value_d = load_val_i;
      end else if (dec_i && (value_q != '0)) begin
         value_d = value_q - PERIOD_W'(1);
      end
   end

   always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
      if (SC_RegSHIFTER_RESET_InHigh) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign expire_o = (value_q == PERIOD_W'(1));

endmodule

`default_nettype wire

// File: rtl/sc_rand_spawn_scheduler.sv
// +--------------------------------------------------------------------------+
// | sc_rand_spawn_scheduler : periodic random column draw with valid/ready    |
// | offer. Optional no-repeat policy under macro SC_SPAWN_NO_REPEAT_EN.       |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_rand_spawn_scheduler
   import sc_spawn_pkg::*;
#(
   parameter  int RAND_W    = 8,
   parameter  int NUM_COLS  = 8,
   parameter  int PERIOD_W  = 26,
   parameter  int MAX_RETRY = 3,
   localparam int COL_W     = sc_col_width(NUM_COLS)
) (
   input  logic                SC_RegSHIFTER_CLOCK_50,
   input  logic                SC_RegSHIFTER_RESET_InHigh,
   input  logic [RAND_W-1:0]   rand_in,
   input  logic                enable_in,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                spawn_ready_in,
   output logic                spawn_valid_out,
   output logic [COL_W-1:0]    spawn_col_out,
   output logic [7:0]          spawn_count_out
);

   localparam int                RETRY_W   = sc_col_width(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [COL_W:0]     NUMC_EXT  = (COL_W+1)'(NUM_COLS);

   spawn_state_t       state_q;
   logic [RETRY_W-1:0] retry_q;
   logic               valid_q;
   logic [COL_W-1:0]   col_q;
   logic [7:0]         count_q;

   logic [PERIOD_W-1:0] period_eff;
   logic [COL_W-1:0]    draw_col;
   logic                in_range;
   logic                accept;
   logic [COL_W-1:0]    fallback_col;
   logic                handshake;
   logic                tmr_load;
   logic                tmr_dec;
   logic                tmr_expire;

   assign period_eff = (period_in == '0) ? PERIOD_W'(1) : period_in;
   assign draw_col   = rand_in[COL_W-1:0];
   assign in_range   = ({1'b0, draw_col} < NUMC_EXT);
   assign handshake  = valid_q && spawn_ready_in;

`ifdef SC_SPAWN_NO_REPEAT_EN
   logic [COL_W-1:0] last_q;

   assign accept       = in_range && (draw_col != last_q);
   assign fallback_col = ({1'b0, last_q} == (NUMC_EXT - (COL_W+1)'(1))) ? '0
                                                                       : last_q + COL_W'(1);
`else
   assign accept       = in_range;
   // Out-of-range values lie below 2*NUM_COLS, so one subtraction folds them into range.
   assign fallback_col = draw_col - NUMC_EXT[COL_W-1:0];
`endif

   assign tmr_load = ((state_q == ST_IDLE) && enable_in) ||
                     ((state_q == ST_OFFER) && handshake && enable_in);
   assign tmr_dec  = (state_q == ST_COUNT) && enable_in && !tmr_expire;

   sc_spawn_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .SC_RegSHIFTER_CLOCK_50     (SC_RegSHIFTER_CLOCK_50),
      .SC_RegSHIFTER_RESET_InHigh (SC_RegSHIFTER_RESET_InHigh),
      .load_i                     (tmr_load),
      .load_val_i                 (period_eff),
      .dec_i                      (tmr_dec),
      .expire_o                   (tmr_expire)
   );

   always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
      if (SC_RegSHIFTER_RESET_InHigh) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
         valid_q <= 1'b0;
         col_q   <= '0;
         count_q <= '0;
`ifdef SC_SPAWN_NO_REPEAT_EN
         last_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_in) state_q <= ST_COUNT;
            end
            ST_COUNT: begin
               if (!enable_in) begin
                  state_q <= ST_IDLE;
               end else if (tmr_expire) begin
                  state_q <= ST_DRAW;
               end
            end
            ST_DRAW: begin
               if (!enable_in) begin
                  state_q <= ST_IDLE;
                  retry_q <= '0;
               end else if (accept) begin
                  col_q   <= draw_col;
                  valid_q <= 1'b1;
                  retry_q <= '0;
                  state_q <= ST_OFFER;
               end else if (retry_q == RETRY_MAX) begin
                  col_q   <= fallback_col;
                  valid_q <= 1'b1;
                  retry_q <= '0;
                  state_q <= ST_OFFER;
               end else begin
                  retry_q <= retry_q + RETRY_W'(1);
               end
            end
            ST_OFFER: begin
               // Offer is held until taken, regardless of enable_in.
               if (handshake) begin
                  valid_q <= 1'b0;
                  if (count_q != COUNT_SAT) count_q <= count_q + 8'd1;
`ifdef SC_SPAWN_NO_REPEAT_EN
                  last_q  <= col_q;
`endif
                  state_q <= enable_in ? ST_COUNT : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign spawn_valid_out = valid_q;
   assign spawn_col_out   = col_q;
   assign spawn_count_out = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sc_rand_spawn_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_sc_rand_spawn_scheduler : directed vectors for the spawn scheduler     |
// | Rev 1.0  initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sc_rand_spawn_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        rdy = 1'b1;
   logic [25:0] per = 26'd4;
   logic [7:0]  rnd = 8'hA5;

   logic        v8, v5;
   logic [2:0]  c8, c5;
   logic [7:0]  n8, n5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sc_rand_spawn_scheduler #(
      .RAND_W(8), .NUM_COLS(8), .PERIOD_W(26), .MAX_RETRY(3)
   ) dut8 (
      .SC_RegSHIFTER_CLOCK_50     (clk),
      .SC_RegSHIFTER_RESET_InHigh (rst),
      .rand_in                    (rnd),
      .enable_in                  (en),
      .period_in                  (per),
      .spawn_ready_in             (rdy),
      .spawn_valid_out            (v8),
      .spawn_col_out              (c8),
      .spawn_count_out            (n8)
   );

   sc_rand_spawn_scheduler #(
      .RAND_W(8), .NUM_COLS(5), .PERIOD_W(26), .MAX_RETRY(3)
   ) dut5 (
      .SC_RegSHIFTER_CLOCK_50     (clk),
      .SC_RegSHIFTER_RESET_InHigh (rst),
      .rand_in                    (rnd),
      .enable_in                  (en),
      .period_in                  (per),
      .spawn_ready_in             (rdy),
      .spawn_valid_out            (v5),
      .spawn_col_out              (c5),
      .spawn_count_out            (n5)
   );

   typedef struct {
      logic        en;
      logic        rdy;
      logic [25:0] per;
      logic [7:0]  rnd;
      int          n;
      logic        ev;
      logic [2:0]  ec;
      logic [7:0]  ecnt;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 26'd4, 8'hA5, 5,  1'b0, 3'd0, 8'd0};
      tbl[1]  = '{1'b1, 1'b1, 26'd4, 8'hA5, 1,  1'b1, 3'd5, 8'd0};
      tbl[2]  = '{1'b1, 1'b1, 26'd4, 8'hA5, 1,  1'b0, 3'd0, 8'd1};
      tbl[3]  = '{1'b1, 1'b1, 26'd4, 8'h3A, 4,  1'b0, 3'd0, 8'd1};
      tbl[4]  = '{1'b1, 1'b1, 26'd4, 8'h3A, 1,  1'b1, 3'd2, 8'd1};
      tbl[5]  = '{1'b1, 1'b0, 26'd4, 8'h3A, 1,  1'b1, 3'd2, 8'd1};
      tbl[6]  = '{1'b0, 1'b0, 26'd4, 8'h3A, 10, 1'b1, 3'd2, 8'd1};
      tbl[7]  = '{1'b0, 1'b1, 26'd4, 8'h3A, 1,  1'b0, 3'd0, 8'd2};
      tbl[8]  = '{1'b0, 1'b1, 26'd4, 8'h3A, 3,  1'b0, 3'd0, 8'd2};
      tbl[9]  = '{1'b1, 1'b1, 26'd4, 8'h3A, 3,  1'b0, 3'd0, 8'd2};
      tbl[10] = '{1'b0, 1'b1, 26'd4, 8'h3A, 1,  1'b0, 3'd0, 8'd2};
      tbl[11] = '{1'b0, 1'b1, 26'd4, 8'h3A, 8,  1'b0, 3'd0, 8'd2};

      // Reset state
      step(2);
      chk("rst_valid8", 32'(v8), 32'd0);
      chk("rst_col8",   32'(c8), 32'd0);
      chk("rst_count8", 32'(n8), 32'd0);
      chk("rst_valid5", 32'(v5), 32'd0);
      rst = 1'b0;

      // Main timeline on the 8-column instance
      for (int i = 0; i < 12; i++) begin
         en  = tbl[i].en;
         rdy = tbl[i].rdy;
         per = tbl[i].per;
         rnd = tbl[i].rnd;
         step(tbl[i].n);
         chk($sformatf("tbl%0d_valid", i), 32'(v8), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("tbl%0d_col", i), 32'(c8), 32'(tbl[i].ec));
         chk($sformatf("tbl%0d_count", i), 32'(n8), 32'(tbl[i].ecnt));
      end

      // Reset while counting, then a full-length restart, then reset mid-offer
      en = 1'b1; per = 26'd4; rnd = 8'hA5; rdy = 1'b1;
      step(3);
      #2 rst = 1'b1;
      #1;
      chk("midcount_rst_valid", 32'(v8), 32'd0);
      chk("midcount_rst_count", 32'(n8), 32'd0);
      step(2);
      rst = 1'b0;
      rdy = 1'b0;
      step(5);
      chk("restart_wait_valid", 32'(v8), 32'd0);
      step(1);
      chk("restart_valid", 32'(v8), 32'd1);
      chk("restart_col",   32'(c8), 32'd5);
      step(2);
      chk("offer_hold_valid", 32'(v8), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midoffer_rst_valid", 32'(v8), 32'd0);
      step(2);
      rst = 1'b0;

      // Five-column instance: rejection and fallback
      en = 1'b1; per = 26'd1; rnd = 8'h07; rdy = 1'b0;
      step(5);
      chk("rej_wait_valid5", 32'(v5), 32'd0);
      step(1);
      chk("rej_valid5", 32'(v5), 32'd1);
`ifdef SC_SPAWN_NO_REPEAT_EN
      chk("rej_col5", 32'(c5), 32'd1);
`else
      chk("rej_col5", 32'(c5), 32'd2);
`endif
      step(2);
      chk("rej_hold5", 32'(v5), 32'd1);
      en = 1'b0; rdy = 1'b1;
      step(1);
      chk("rej_done_valid5", 32'(v5), 32'd0);
      chk("rej_done_count5", 32'(n5), 32'd1);
      en = 1'b1; rnd = 8'h03; rdy = 1'b0;
      step(2);
      chk("inrange_wait5", 32'(v5), 32'd0);
      step(1);
      chk("inrange_valid5", 32'(v5), 32'd1);
      chk("inrange_col5",   32'(c5), 32'd3);
      en = 1'b0; rdy = 1'b1;
      step(1);
      chk("inrange_count5", 32'(n5), 32'd2);
      en = 1'b1; rnd = 8'h07;
      step(2);
      en = 1'b0;
      step(7);
      chk("drawdrop_valid5", 32'(v5), 32'd0);
      chk("drawdrop_count5", 32'(n5), 32'd2);

      // Period 0 behaves as 1; offers every 3 cycles; count saturates
      do_reset();
      per = 26'd0; rdy = 1'b1; en = 1'b1;
      for (int s = 1; s <= 920; s++) begin
         rnd = s[7:0];
         step(1);
         if (s <= 30) begin
            chk($sformatf("p0_valid_s%0d", s), 32'(v8), 32'((s % 3) == 0));
            chk($sformatf("p0_count_s%0d", s), 32'(n8), 32'((s - 1) / 3));
         end
         if (s == 765) chk("sat_count_254", 32'(n8), 32'd254);
         if (s == 766) chk("sat_count_255", 32'(n8), 32'd255);
      end
      chk("sat_count_end", 32'(n8), 32'd255);

      // Fixed random value: repeat policy
      en = 1'b0;
      do_reset();
      per = 26'd1; rnd = 8'h02; rdy = 1'b1; en = 1'b1;
      step(3);
      chk("rep_first_valid", 32'(v8), 32'd1);
      chk("rep_first_col",   32'(c8), 32'd2);
      step(3);
`ifdef SC_SPAWN_NO_REPEAT_EN
      chk("norep_wait_valid", 32'(v8), 32'd0);
      step(3);
      chk("norep_valid", 32'(v8), 32'd1);
      chk("norep_col",   32'(c8), 32'd3);
      chk("norep_count", 32'(n8), 32'd1);
`else
      chk("rep_second_valid", 32'(v8), 32'd1);
      chk("rep_second_col",   32'(c8), 32'd2);
      chk("rep_second_count", 32'(n8), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
